inst_fetch: RTL and testbench

- IF-stage bus master that sits directly downstream of the PC register. Takes its pc/ce, issues one instruction-memory read at a time over a split address/data handshake, and returns pc_read_ready so the PC register may advance.
- Delivers the fetched (pc, instruction) pair to the IF/ID pipeline register.
- Honours stall from CTRL and discards in-flight fetches on flush.

---
 rtl/inst_fetch_pkg.sv | 18 +
 rtl/inst_fetch.sv | 129 ++++++++++++
 tb/tb_inst_fetch.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the IF-stage fetch unit: FSM states, NOP word,
// handshake constants and the AdEL exception code.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
  localparam logic        READY       = 1'b1;
  localparam logic        VALID       = 1'b1;
  localparam logic        CHIP_ENABLE = 1'b1;
  localparam logic [4:0]  EXC_ADEL    = 5'h04;

endpackage

// File: rtl/inst_fetch.sv
// IF-stage instruction bus master: one outstanding read, split addr/data
// handshake, stall/flush aware output buffer. Optional FETCH_ADDR_CHECK_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_INST = NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ce,
  input  logic              stall,
  input  logic              flush,
  output logic              pc_read_ready,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
`ifdef FETCH_ADDR_CHECK_EN
  output logic              if_excp_adel,
`endif
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst
);

  fetch_state_t      r_state;
  logic              r_if_valid;
  logic [ADDR_W-1:0] r_if_pc;
  logic [DATA_W-1:0] r_if_inst;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_discard;
  logic              w_misaligned;
  logic              w_in_req;
  logic              w_inst_req;
  logic              w_pc_read_ready;
`ifdef FETCH_ADDR_CHECK_EN
  logic              r_excp_adel;
`endif

  always_comb begin
`ifdef FETCH_ADDR_CHECK_EN
    w_misaligned = (pc[1:0] != 2'b00);
`else
    w_misaligned = 1'b0;
`endif
    w_in_req        = (r_state == S_REQ) && (ce == CHIP_ENABLE);
    w_inst_req      = w_in_req && !w_misaligned;
    // A misaligned pc completes its "handshake" locally so the PC register advances.
    w_pc_read_ready = (w_inst_req && inst_addr_ok) || (w_in_req && w_misaligned);
  end

  assign inst_req      = w_inst_req;
  assign inst_addr     = pc;
  assign pc_read_ready = w_pc_read_ready;
  assign if_valid      = r_if_valid;
  assign if_pc         = r_if_pc;
  assign if_inst       = r_if_inst;
`ifdef FETCH_ADDR_CHECK_EN
  assign if_excp_adel  = r_excp_adel;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_inst  <= NOP_INST;
      r_req_pc   <= '0;
      r_discard  <= 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
      r_excp_adel <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ce == CHIP_ENABLE && !r_if_valid) r_state <= S_REQ;
        end
        S_REQ: begin
          if (ce != CHIP_ENABLE) begin
            r_state <= S_IDLE;
          end else if (w_misaligned) begin
            r_state    <= S_HOLD;
            r_if_valid <= VALID;
            r_if_pc    <= pc;
            r_if_inst  <= NOP_INST;
`ifdef FETCH_ADDR_CHECK_EN
            r_excp_adel <= 1'b1;
`endif
          end else if (inst_addr_ok == READY) begin
            r_state  <= S_WAIT;
            r_req_pc <= pc;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            // Data answering a flushed request is dropped; refetch from the new pc.
            if (r_discard || flush) begin
              r_discard <= 1'b0;
              r_state   <= S_REQ;
            end else begin
              r_if_valid <= VALID;
              r_if_pc    <= r_req_pc;
              r_if_inst  <= inst_rdata;
              r_state    <= S_HOLD;
            end
          end else if (flush) begin
            r_discard <= 1'b1;
          end
        end
        S_HOLD: begin
          if (flush || !stall) begin
            r_if_valid <= 1'b0;
            r_if_inst  <= NOP_INST;
`ifdef FETCH_ADDR_CHECK_EN
            r_excp_adel <= 1'b0;
`endif
            r_state <= (flush || ce == CHIP_ENABLE) ? S_REQ : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed bus handshakes, expected deliveries
// queued by stimulus and checked by an independent monitor on if_valid rising.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        ce, stall, flush;
  logic        pc_read_ready, inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;
`ifdef FETCH_ADDR_CHECK_EN
  logic        if_excp_adel;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  inst_fetch #(.ADDR_W(32), .DATA_W(32), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc(pc), .ce(ce), .stall(stall), .flush(flush),
    .pc_read_ready(pc_read_ready), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
`ifdef FETCH_ADDR_CHECK_EN
    .if_excp_adel(if_excp_adel),
`endif
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i);
    exp_t e;
    e.pc = p;
    e.inst = i;
    exp_q.push_back(e);
  endtask

  // Monitor: each new presentation on if_* must match the oldest queued fetch.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (if_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_deliver", 64'(if_pc), 64'hffff_ffff_ffff_ffff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("deliver_pc", 64'(if_pc), 64'(e.pc));
          check("deliver_inst", 64'(if_inst), 64'(e.inst));
        end
      end
      prev_valid = if_valid;
    end
  end

  initial begin
    rst = 1'b1; ce = 1'b0; pc = '0; stall = 1'b0; flush = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    #12;
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_if_pc", 64'(if_pc), 64'd0);
    check("rst_if_inst", 64'(if_inst), 64'(NOP));
    check("rst_inst_req", 64'(inst_req), 64'd0);
    check("rst_pc_read_ready", 64'(pc_read_ready), 64'd0);
    step;
    rst = 1'b0;
    step;

    // Basic fetch
    ce = 1'b1; pc = 32'hbfc00000;
    #1 check("idle_no_req", 64'(inst_req), 64'd0);
    step;
    inst_addr_ok = 1'b1; #1;
    check("basic_req", 64'(inst_req), 64'd1);
    check("basic_addr", 64'(inst_addr), 64'hbfc00000);
    check("basic_prr", 64'(pc_read_ready), 64'd1);
    push(32'hbfc00000, 32'h24080001);
    step;
    inst_addr_ok = 1'b0; ce = 1'b0; #1;
    check("wait_no_req", 64'(inst_req), 64'd0);
    check("wait_no_prr", 64'(pc_read_ready), 64'd0);
    step;
    inst_data_ok = 1'b1; inst_rdata = 32'h24080001;
    step;
    inst_data_ok = 1'b0; inst_rdata = '0; #1;
    check("basic_valid", 64'(if_valid), 64'd1);
    step;
    check("basic_valid_1cyc", 64'(if_valid), 64'd0);
    check("basic_nop_after", 64'(if_inst), 64'(NOP));

    // Stall hold
    ce = 1'b1; pc = 32'hbfc00004; stall = 1'b1;
    step;
    inst_addr_ok = 1'b1;
    push(32'hbfc00004, 32'h3c1d0000);
    step;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3c1d0000;
    step;
    inst_data_ok = 1'b0; inst_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_valid", 64'(if_valid), 64'd1);
      check("stall_pc", 64'(if_pc), 64'hbfc00004);
      check("stall_inst", 64'(if_inst), 64'h3c1d0000);
      check("stall_no_req", 64'(inst_req), 64'd0);
      step;
    end
    stall = 1'b0; pc = 32'hbfc00008; #1;
    check("stall_release_valid", 64'(if_valid), 64'd1);
    step;
    #1;
    check("reissue_valid0", 64'(if_valid), 64'd0);
    check("reissue_req", 64'(inst_req), 64'd1);
    check("reissue_addr", 64'(inst_addr), 64'hbfc00008);
    ce = 1'b0; #1;
    check("ce_drop_req", 64'(inst_req), 64'd0);
    step;

    // Flush in WAIT: stale data dropped, refetch from new pc
    ce = 1'b1; pc = 32'hbfc00008;
    step;
    inst_addr_ok = 1'b1;
    step;
    inst_addr_ok = 1'b0; flush = 1'b1; pc = 32'hbfc00380;
    step;
    flush = 1'b0;
    step;
    inst_data_ok = 1'b1; inst_rdata = 32'hdeadbeef;
    step;
    inst_data_ok = 1'b0; inst_rdata = '0; #1;
    check("flush_no_valid", 64'(if_valid), 64'd0);
    check("flush_req", 64'(inst_req), 64'd1);
    check("flush_new_addr", 64'(inst_addr), 64'hbfc00380);
    inst_addr_ok = 1'b1;
    push(32'hbfc00380, 32'h24090002);
    step;
    inst_addr_ok = 1'b0; ce = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h24090002;
    step;
    inst_data_ok = 1'b0; inst_rdata = '0;
    step;

    // Bus back-pressure
    ce = 1'b1; pc = 32'hbfc00010;
    step;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_req", 64'(inst_req), 64'd1);
      check("bp_addr", 64'(inst_addr), 64'hbfc00010);
      check("bp_prr", 64'(pc_read_ready), 64'd0);
      step;
    end
    inst_addr_ok = 1'b1; #1;
    check("bp_accept_prr", 64'(pc_read_ready), 64'd1);
    push(32'hbfc00010, 32'h8fa40010);
    step;
    inst_addr_ok = 1'b0; ce = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h8fa40010;
    step;
    inst_data_ok = 1'b0; inst_rdata = '0;
    step;

    // Async reset mid-WAIT
    ce = 1'b1; pc = 32'hbfc00020;
    step;
    inst_addr_ok = 1'b1;
    step;
    inst_addr_ok = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_req", 64'(inst_req), 64'd0);
    check("arst_valid", 64'(if_valid), 64'd0);
    check("arst_prr", 64'(pc_read_ready), 64'd0);
    step;
    rst = 1'b0; #1;
    check("arst_idle", 64'(inst_req), 64'd0);
    step;
    check("arst_restart_req", 64'(inst_req), 64'd1);
    check("arst_restart_addr", 64'(inst_addr), 64'hbfc00020);
    inst_addr_ok = 1'b1;
    push(32'hbfc00020, 32'h27bdfff8);
    step;
    inst_addr_ok = 1'b0; ce = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h27bdfff8;
    step;
    inst_data_ok = 1'b0; inst_rdata = '0;
    step;

`ifdef FETCH_ADDR_CHECK_EN
    ce = 1'b1; pc = 32'hbfc00002;
    step;
    #1;
    check("adel_no_req", 64'(inst_req), 64'd0);
    check("adel_prr", 64'(pc_read_ready), 64'd1);
    push(32'hbfc00002, NOP);
    step;
    ce = 1'b0; #1;
    check("adel_flag", 64'(if_excp_adel), 64'd1);
    check("adel_valid", 64'(if_valid), 64'd1);
    step;
    check("adel_clear", 64'(if_excp_adel), 64'd0);
`endif

    step;
    step;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
